// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the game event generator
package game_pkg;

    localparam int COORD_W = 10;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        IDLE,
        PLAY,
        GRACE,
        DEAD,
        WAIT
    } evt_state_t;

endpackage

// File: rtl/sprite_hit.sv
// rtl/sprite_hit.sv - combinational box-overlap test for one sprite pair
module sprite_hit #(
    parameter int COORD_W  = 10,
    parameter int HIT_DIST = 12
) (
    input  logic [COORD_W-1:0] a_x_i,
    input  logic [COORD_W-1:0] a_y_i,
    input  logic [COORD_W-1:0] b_x_i,
    input  logic [COORD_W-1:0] b_y_i,
    output logic               hit_o
);

    logic [COORD_W:0] dx, dy, adx, ady;

    // One extra bit keeps the borrow so the magnitude never wraps.
    assign dx  = {1'b0, a_x_i} - {1'b0, b_x_i};
    assign dy  = {1'b0, a_y_i} - {1'b0, b_y_i};
    assign adx = dx[COORD_W] ? (~dx + 1'b1) : dx;
    assign ady = dy[COORD_W] ? (~dy + 1'b1) : dy;

    assign hit_o = (adx < (COORD_W+1)'(HIT_DIST)) && (ady < (COORD_W+1)'(HIT_DIST));

endmodule

// File: rtl/game_event_gen.sv
// rtl/game_event_gen.sv - start debounce, collision, lives and death events for the game FSM
module game_event_gen
    import game_pkg::*;
#(
    parameter int         COORD_W      = game_pkg::COORD_W,
    parameter int         HIT_DIST     = 12,
    parameter int         LIVES        = 3,
    parameter logic [7:0] START_KEY    = KEY_ENTER,
    parameter int         START_HOLD   = 4,
    parameter int         GRACE_FRAMES = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_sync,
    input  logic [7:0]         keycode,
    input  logic [COORD_W-1:0] pac_x,
    input  logic [COORD_W-1:0] pac_y,
    input  logic [COORD_W-1:0] g0_x,
    input  logic [COORD_W-1:0] g0_y,
    input  logic [COORD_W-1:0] g1_x,
    input  logic [COORD_W-1:0] g1_y,
    input  logic               start,
    input  logic               endgame,
    output logic               begingame,
    output logic               died,
    output logic               respawn,
    output logic [1:0]         lives,
    output logic               invuln
);

    localparam int HW = $clog2(START_HOLD + 1);
    localparam int GW = $clog2(GRACE_FRAMES + 1);

    evt_state_t         state_q, state_d;
    logic [COORD_W-1:0] pac_x_q, pac_y_q, g0_x_q, g0_y_q, g1_x_q, g1_y_q;
    logic [7:0]         key_q;
    logic               eval_q;
    logic [HW-1:0]      hold_q, hold_d;
    logic [GW-1:0]      grace_q, grace_d;
    logic [1:0]         lives_q, lives_d;
    logic               begingame_q, begingame_d;
    logic               died_q, died_d;
    logic               respawn_q, respawn_d;
    logic               invuln_q, invuln_d;
    logic               hit0, hit1, hit;

    sprite_hit #(.COORD_W(COORD_W), .HIT_DIST(HIT_DIST)) u_hit0 (
        .a_x_i(pac_x_q), .a_y_i(pac_y_q), .b_x_i(g0_x_q), .b_y_i(g0_y_q), .hit_o(hit0)
    );
    sprite_hit #(.COORD_W(COORD_W), .HIT_DIST(HIT_DIST)) u_hit1 (
        .a_x_i(pac_x_q), .a_y_i(pac_y_q), .b_x_i(g1_x_q), .b_y_i(g1_y_q), .hit_o(hit1)
    );

    // Both ghosts hitting at once is still a single event.
    assign hit = eval_q && (hit0 || hit1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pac_x_q     <= '0;
            pac_y_q     <= '0;
            g0_x_q      <= '0;
            g0_y_q      <= '0;
            g1_x_q      <= '0;
            g1_y_q      <= '0;
            key_q       <= '0;
            eval_q      <= 1'b0;
            hold_q      <= '0;
            grace_q     <= '0;
            lives_q     <= '0;
            begingame_q <= 1'b0;
            died_q      <= 1'b0;
            respawn_q   <= 1'b0;
            invuln_q    <= 1'b0;
        end else begin
            if (frame_sync) begin
                pac_x_q <= pac_x;
                pac_y_q <= pac_y;
                g0_x_q  <= g0_x;
                g0_y_q  <= g0_y;
                g1_x_q  <= g1_x;
                g1_y_q  <= g1_y;
                key_q   <= keycode;
            end
            eval_q      <= frame_sync;
            state_q     <= state_d;
            hold_q      <= hold_d;
            grace_q     <= grace_d;
            lives_q     <= lives_d;
            begingame_q <= begingame_d;
            died_q      <= died_d;
            respawn_q   <= respawn_d;
            invuln_q    <= invuln_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        grace_d     = grace_q;
        lives_d     = lives_q;
        begingame_d = 1'b0;
        died_d      = 1'b0;
        respawn_d   = 1'b0;
        invuln_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!start) begin
                    hold_d = '0;
                end else if (eval_q) begin
                    if (key_q != START_KEY) begin
                        hold_d = '0;
                    end else if (hold_q + 1'b1 >= HW'(START_HOLD)) begin
                        begingame_d = 1'b1;
                        lives_d     = 2'(LIVES);
                        hold_d      = '0;
                        state_d     = PLAY;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            PLAY: begin
                if (start) begin
                    lives_d = '0;
                    grace_d = '0;
                    state_d = IDLE;
                end else if (hit) begin
                    if (lives_q > 2'd1) begin
                        lives_d   = lives_q - 2'd1;
                        respawn_d = 1'b1;
                        invuln_d  = 1'b1;
                        grace_d   = GW'(GRACE_FRAMES);
                        state_d   = GRACE;
                    end else begin
                        lives_d = '0;
                        died_d  = 1'b1;
                        state_d = DEAD;
                    end
                end
            end
            GRACE: begin
                invuln_d = 1'b1;
                if (start) begin
                    lives_d  = '0;
                    grace_d  = '0;
                    invuln_d = 1'b0;
                    state_d  = IDLE;
                end else if (eval_q) begin
                    // Grace ends on this frame; the next frame is the first one checked.
                    if (grace_q <= GW'(1)) begin
                        grace_d  = '0;
                        invuln_d = 1'b0;
                        state_d  = PLAY;
                    end else begin
                        grace_d = grace_q - 1'b1;
                    end
                end
            end
            DEAD: begin
                died_d = 1'b1;
                if (endgame) begin
                    died_d  = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (start) begin
                    lives_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign begingame = begingame_q;
    assign died      = died_q;
    assign respawn   = respawn_q;
    assign lives     = lives_q;
    assign invuln    = invuln_q;

endmodule

// File: tb/tb_game_event_gen.sv
// tb/tb_game_event_gen.sv - self-checking bench for game_event_gen
module tb_game_event_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_sync = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic [9:0] pac_x = 10'd100, pac_y = 10'd100;
    logic [9:0] g0_x = 10'd400, g0_y = 10'd400;
    logic [9:0] g1_x = 10'd500, g1_y = 10'd300;
    logic       start = 1'b0;
    logic       endgame = 1'b0;
    logic       begingame, died, respawn, invuln;
    logic [1:0] lives;

    int n_tests = 0;
    int n_fail  = 0;
    int bg_cnt  = 0;
    int rs_cnt  = 0;

    game_event_gen dut (
        .clk(clk), .reset(reset), .frame_sync(frame_sync), .keycode(keycode),
        .pac_x(pac_x), .pac_y(pac_y), .g0_x(g0_x), .g0_y(g0_y),
        .g1_x(g1_x), .g1_y(g1_y), .start(start), .endgame(endgame),
        .begingame(begingame), .died(died), .respawn(respawn),
        .lives(lives), .invuln(invuln)
    );

    always #5 clk = ~clk;

    // Model: game phase, remaining lives, held key frames, invulnerable frames left.
    localparam int M_IDLE = 0, M_PLAY = 1, M_GRACE = 2, M_DEAD = 3, M_WAIT = 4;
    int m_phase = M_IDLE, m_lives = 0, m_held = 0, m_grace_left = 0;
    bit m_frame_pending = 0;
    int s_px, s_py, s_g0x, s_g0y, s_g1x, s_g1y, s_key;
    bit e_bg = 0, e_died = 0, e_resp = 0, e_inv = 0;

    function automatic bit near(int ax, int ay, int bx, int by);
        int dx = ax - bx;
        int dy = ay - by;
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        return (dx < 12) && (dy < 12);
    endfunction

    task automatic model_step();
        bit collided;
        if (reset) begin
            m_phase = M_IDLE; m_lives = 0; m_held = 0; m_grace_left = 0;
            m_frame_pending = 0;
            e_bg = 0; e_died = 0; e_resp = 0; e_inv = 0;
            return;
        end
        collided = m_frame_pending &&
                   (near(s_px, s_py, s_g0x, s_g0y) || near(s_px, s_py, s_g1x, s_g1y));
        e_bg = 0; e_resp = 0;
        if (m_phase == M_IDLE) begin
            if (!start) m_held = 0;
            else if (m_frame_pending) begin
                if (s_key == 40) begin
                    m_held = m_held + 1;
                    if (m_held == 4) begin
                        e_bg = 1; m_lives = 3; m_held = 0; m_phase = M_PLAY;
                    end
                end else m_held = 0;
            end
        end else if (m_phase == M_PLAY || m_phase == M_GRACE) begin
            if (start) begin
                m_phase = M_IDLE; m_lives = 0; m_grace_left = 0; e_inv = 0;
            end else if (m_phase == M_PLAY && collided) begin
                if (m_lives > 1) begin
                    m_lives = m_lives - 1; e_resp = 1; e_inv = 1;
                    m_grace_left = 60; m_phase = M_GRACE;
                end else begin
                    m_lives = 0; e_died = 1; m_phase = M_DEAD;
                end
            end else if (m_phase == M_GRACE && m_frame_pending) begin
                m_grace_left = m_grace_left - 1;
                if (m_grace_left == 0) begin
                    e_inv = 0; m_phase = M_PLAY;
                end
            end
        end else if (m_phase == M_DEAD) begin
            if (endgame) begin
                e_died = 0; m_phase = M_WAIT;
            end
        end else if (m_phase == M_WAIT) begin
            if (start) begin
                m_lives = 0; m_phase = M_IDLE;
            end
        end
        m_frame_pending = frame_sync;
        if (frame_sync) begin
            s_px = int'(pac_x); s_py = int'(pac_y);
            s_g0x = int'(g0_x); s_g0y = int'(g0_y);
            s_g1x = int'(g1_x); s_g1y = int'(g1_y);
            s_key = int'(keycode);
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (begingame) bg_cnt++;
        if (respawn) rs_cnt++;
        if (!reset) begin
            n_tests++;
            if ({begingame, died, respawn, lives, invuln} !==
                {e_bg, e_died, e_resp, 2'(m_lives), e_inv}) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t got bg=%b died=%b resp=%b lives=%0d inv=%b need bg=%b died=%b resp=%b lives=%0d inv=%b",
                         $time, begingame, died, respawn, lives, invuln,
                         e_bg, e_died, e_resp, m_lives, e_inv);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic frame(input bit drop_start);
        @(negedge clk) frame_sync = 1'b1;
        @(negedge clk) frame_sync = 1'b0;
        @(negedge clk) if (drop_start) start = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic start_game();
        start = 1'b1; keycode = 8'h28;
        repeat (3) frame(1'b0);
        frame(1'b1);
        keycode = 8'h00;
    endtask

    initial begin
        int bg0, rs0;
        repeat (3) @(negedge clk);
        check("reset_lives", int'(lives), 0);
        check("reset_outs", int'({begingame, died, respawn, invuln}), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Three-frame hold then release must not start a game.
        start = 1'b1; keycode = 8'h28;
        repeat (3) frame(1'b0);
        keycode = 8'h00;
        frame(1'b0);
        check("short_hold_no_bg", bg_cnt, 0);
        start_game();
        check("full_hold_one_bg", bg_cnt, 1);
        check("lives_after_start", int'(lives), 3);

        // Exactly HIT_DIST apart is a miss, one closer is a hit.
        g0_x = 10'd112; g0_y = 10'd100;
        frame(1'b0);
        check("edge_no_hit_lives", int'(lives), 3);
        g0_x = 10'd111;
        rs0 = rs_cnt;
        frame(1'b0);
        check("hit_lives", int'(lives), 2);
        check("hit_respawn_once", rs_cnt - rs0, 1);
        check("hit_invuln", int'(invuln), 1);

        // Ghost stays on pacman through the whole grace period.
        repeat (59) frame(1'b0);
        check("grace_59_lives", int'(lives), 2);
        check("grace_59_invuln", int'(invuln), 1);
        frame(1'b0);
        check("grace_end_lives", int'(lives), 2);
        check("grace_end_invuln", int'(invuln), 0);
        frame(1'b0);
        check("post_grace_hit", int'(lives), 1);

        // Clear the grace period, then take the final hit.
        g0_x = 10'd400; g0_y = 10'd400;
        repeat (60) frame(1'b0);
        check("lives1_playing", int'({lives, invuln}), 2);
        g0_x = 10'd100; g0_y = 10'd100;
        frame(1'b0);
        g0_x = 10'd400; g0_y = 10'd400;
        check("died_set", int'(died), 1);
        check("died_lives0", int'(lives), 0);
        repeat (20) @(negedge clk);
        check("died_held", int'(died), 1);
        endgame = 1'b1;
        @(negedge clk);
        check("died_cleared", int'(died), 0);
        endgame = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);

        // Second game: both ghosts overlap in the same frame.
        bg0 = bg_cnt;
        start_game();
        check("game2_bg", bg_cnt - bg0, 1);
        g0_x = 10'd105; g0_y = 10'd95;
        g1_x = 10'd95;  g1_y = 10'd105;
        frame(1'b0);
        check("double_hit_lives", int'(lives), 2);
        g0_x = 10'd400; g0_y = 10'd400;
        g1_x = 10'd500; g1_y = 10'd300;
        repeat (30) frame(1'b0);

        // Asynchronous reset mid-cycle during grace.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_lives", int'(lives), 0);
        check("async_invuln", int'(invuln), 0);
        check("async_pulses", int'({begingame, died, respawn}), 0);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        bg0 = bg_cnt;
        start = 1'b1; keycode = 8'h28;
        repeat (3) frame(1'b0);
        check("after_reset_3_frames", bg_cnt - bg0, 0);
        frame(1'b1);
        check("after_reset_4_frames", bg_cnt - bg0, 1);
        check("after_reset_lives", int'(lives), 3);
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
